sync_updown_counter: RTL



---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_next_val.sv | 58 +++++
 rtl/sync_updown_counter.sv | 79 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the synchronous counter family.
package counter_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // True when the count range 0..modulus-1 fits in a width-bit register.
   function automatic bit modulus_ok(input int width, input int modulus);
      return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
   endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count logic: load clamping, step arithmetic and end detection.
module counter_next_val
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = CNT_WRAP
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] next_q,
   output logic             end_hit,
   output logic             range_err
);

   localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0] q_ext;
   logic [WIDTH:0] ld_ext;
   logic [WIDTH:0] inc;
   logic [WIDTH:0] dec;

   // The extra bit keeps the end-of-range test independent of 2^WIDTH wrap.
   always_comb begin
      q_ext     = {1'b0, q};
      ld_ext    = {1'b0, load_val};
      inc       = q_ext + 1'b1;
      dec       = q_ext - 1'b1;
      next_q    = q;
      end_hit   = 1'b0;
      range_err = 1'b0;
      if (load) begin
         if (ld_ext > MAX_VAL) begin
            next_q    = MAX_VAL[WIDTH-1:0];
            range_err = 1'b1;
         end else begin
            next_q = load_val;
         end
      end else if (up == DIR_UP) begin
         if (inc > MAX_VAL) begin
            end_hit = 1'b1;
            next_q  = (SATURATE == CNT_SAT) ? q : '0;
         end else begin
            next_q = inc[WIDTH-1:0];
         end
      end else begin
         if (dec[WIDTH]) begin
            end_hit = 1'b1;
            next_q  = (SATURATE == CNT_SAT) ? q : MAX_VAL[WIDTH-1:0];
         end else begin
            next_q = dec[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/sync_updown_counter.sv
// Single-clock programmable-modulus up/down counter with load, terminal count
// and sticky over/underflow/load-error flags.
module sync_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = CNT_WRAP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             unf,
   output logic             load_err,
   input  logic             clr_flags
);

   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("sync_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
   end

   logic [WIDTH-1:0] next_q;
   logic             end_hit;
   logic             range_err;
   logic             step;
   logic             set_ovf;
   logic             set_unf;
   logic             set_lerr;

   counter_next_val #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next (
      .q         (q),
      .up        (up),
      .load      (load),
      .load_val  (load_val),
      .next_q    (next_q),
      .end_hit   (end_hit),
      .range_err (range_err)
   );

   assign step     = en && !load;
   assign set_ovf  = step && end_hit && (up == DIR_UP);
   assign set_unf  = step && end_hit && (up == DIR_DOWN);
   assign set_lerr = load && range_err;

   // Flag-setting events outrank a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         q        <= '0;
         tc       <= 1'b0;
         ovf      <= 1'b0;
         unf      <= 1'b0;
         load_err <= 1'b0;
      end else begin
         if (load) begin
            q  <= next_q;
            tc <= 1'b0;
         end else if (en) begin
            q  <= next_q;
            tc <= end_hit;
         end else begin
            tc <= 1'b0;
         end
         ovf      <= (ovf      && !clr_flags) || set_ovf;
         unf      <= (unf      && !clr_flags) || set_unf;
         load_err <= (load_err && !clr_flags) || set_lerr;
      end
   end

endmodule
